display_scan: RTL and testbench

Time-multiplexed eight-digit seven-segment driver. Consumes the eight 6-bit digit words that the game FSM produces (`d1`..`d8`). It scans them onto one shared segment bus with one-hot active-low anodes, and inserts a blanking guard at every digit switch. It sits between the game core and the board display pins and is the decode end of the digit-word encoding.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/seg_decoder.sv | 34 +++
 rtl/display_scan.sv | 88 ++++++++
 tb/tb_display_scan.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the eight-digit display path: digit-word layout,
// glyph code constants and the blank word. The game FSM imports the same
// constants so that encode and decode agree.
package display_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned DIGIT_W    = 6;
   localparam int unsigned CODE_W     = 4;
   localparam int unsigned SEG_W      = 7;

   // Digit word bit positions: {en, code[3:0], dp_n}
   localparam int unsigned EN_BIT   = 5;
   localparam int unsigned CODE_MSB = 4;
   localparam int unsigned CODE_LSB = 1;
   localparam int unsigned DP_BIT   = 0;

   // Letter / symbol glyph codes above the decimal digits
   localparam logic [CODE_W-1:0] CH_C    = 4'hA;
   localparam logic [CODE_W-1:0] CH_J    = 4'hB;
   localparam logic [CODE_W-1:0] CH_U    = 4'hC;
   localparam logic [CODE_W-1:0] CH_P    = 4'hD;
   localparam logic [CODE_W-1:0] CH_E    = 4'hE;
   localparam logic [CODE_W-1:0] CH_DASH = 4'hF;

   // Disabled digit, decimal point off
   localparam logic [DIGIT_W-1:0] BLANK_WORD = 6'b000001;

   typedef struct packed {
      logic              en;
      logic [CODE_W-1:0] code;
      logic              dp_n;
   } digit_t;

   // Unpack a raw digit word into its fields
   function automatic digit_t to_digit(input logic [DIGIT_W-1:0] w);
      digit_t d;
      d.en   = w[EN_BIT];
      d.code = w[CODE_MSB:CODE_LSB];
      d.dp_n = w[DP_BIT];
      return d;
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// Glyph decoder: 4-bit digit code to active-high segments.
// Ports: code (in, 4) glyph code; seg_c (out, 7) combinational {a,b,c,d,e,f,g}.
module seg_decoder
   import display_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [SEG_W-1:0]  seg_c
);

   // Segment order a..g from MSB to LSB
   always_comb begin
      seg_c = '0;
      case (code)
         4'h0:    seg_c = 7'b1111110;
         4'h1:    seg_c = 7'b0110000;
         4'h2:    seg_c = 7'b1101101;
         4'h3:    seg_c = 7'b1111001;
         4'h4:    seg_c = 7'b0110011;
         4'h5:    seg_c = 7'b1011011;
         4'h6:    seg_c = 7'b1011111;
         4'h7:    seg_c = 7'b1110000;
         4'h8:    seg_c = 7'b1111111;
         4'h9:    seg_c = 7'b1111011;
         CH_C:    seg_c = 7'b1001110;
         CH_J:    seg_c = 7'b0111100;
         CH_U:    seg_c = 7'b0111110;
         CH_P:    seg_c = 7'b1100111;
         CH_E:    seg_c = 7'b1001111;
         CH_DASH: seg_c = 7'b0000001;
         default: seg_c = '0;
      endcase
   end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed eight-digit seven-segment scanner with a blanking guard
// at the start of every digit slot and a per-frame snapshot of the inputs.
// Ports: clock, reset (async active-high); d1..d8 (in, 6) digit words,
// d1 rightmost; an (out, 8) active-low one-hot anodes; dec_ddp (out, 8)
// active-low {a,b,c,d,e,f,g,dp}.
module display_scan
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 2
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] d1,
   input  logic [DIGIT_W-1:0] d2,
   input  logic [DIGIT_W-1:0] d3,
   input  logic [DIGIT_W-1:0] d4,
   input  logic [DIGIT_W-1:0] d5,
   input  logic [DIGIT_W-1:0] d6,
   input  logic [DIGIT_W-1:0] d7,
   input  logic [DIGIT_W-1:0] d8,
   output logic [7:0]         an,
   output logic [7:0]         dec_ddp
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   digit_t           frame [NUM_DIGITS];
   digit_t           cur_c;
   logic [SEG_W-1:0] seg_c;
   logic             frame_start_c;

   assign cur_c         = frame[idx];
   assign frame_start_c = (cnt == '0) && (idx == '0);

   seg_decoder u_seg_decoder (
      .code  (cur_c.code),
      .seg_c (seg_c)
   );

   // Slot counter and digit index
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         idx <= idx + 3'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Snapshot of all digit words at frame start, so a frame never tears
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) frame[i] <= '0;
      end else if (frame_start_c) begin
         frame[0] <= to_digit(d1);
         frame[1] <= to_digit(d2);
         frame[2] <= to_digit(d3);
         frame[3] <= to_digit(d4);
         frame[4] <= to_digit(d5);
         frame[5] <= to_digit(d6);
         frame[6] <= to_digit(d7);
         frame[7] <= to_digit(d8);
      end
   end

   // Registered pin drive; guard cycles blank everything between digits
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         an      <= 8'hFF;
         dec_ddp <= 8'hFF;
      end else if (cnt < GUARD_CNT) begin
         an      <= 8'hFF;
         dec_ddp <= 8'hFF;
      end else begin
         an      <= cur_c.en ? ~(8'h01 << idx) : 8'hFF;
         dec_ddp <= {~seg_c, cur_c.dp_n};
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with REFRESH_DIV=4, GUARD=1.
module tb_display_scan;

   localparam int unsigned RD = 4;
   localparam int unsigned GD = 1;

   logic       clock;
   logic       reset;
   logic [5:0] d [8];
   logic [7:0] an;
   logic [7:0] dec_ddp;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected dec_ddp for each code with the point off
   logic [7:0] glyph_dd [16];

   display_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
      .clock   (clock),
      .reset   (reset),
      .d1      (d[0]),
      .d2      (d[1]),
      .d3      (d[2]),
      .d4      (d[3]),
      .d5      (d[4]),
      .d6      (d[5]),
      .d7      (d[6]),
      .d8      (d[7]),
      .an      (an),
      .dec_ddp (dec_ddp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One slot: one guard cycle, then RD-GD lit cycles
   task automatic run_slot(input int s, input logic en, input logic [7:0] dd);
      logic [7:0] exp_an;
      exp_an = en ? ~(8'h01 << s) : 8'hFF;
      tick();
      check($sformatf("slot%0d guard an", s), an, 8'hFF);
      check($sformatf("slot%0d guard dd", s), dec_ddp, 8'hFF);
      for (int c = int'(GD); c < int'(RD); c++) begin
         tick();
         check($sformatf("slot%0d an", s), an, exp_an);
         check($sformatf("slot%0d dd", s), dec_ddp, dd);
         check($sformatf("slot%0d onehot", s), 8'($countones(~an) <= 1), 8'd1);
      end
   endtask

   task automatic run_frame(input logic [7:0] en_mask, input logic [7:0][7:0] dd);
      for (int s = 0; s < 8; s++) run_slot(s, en_mask[s], dd[s]);
   endtask

   task automatic set_all(input logic [5:0] w);
      for (int i = 0; i < 8; i++) d[i] = w;
   endtask

   initial begin
      logic [7:0][7:0] exp_dd;

      glyph_dd[0]  = 8'h03; glyph_dd[1]  = 8'h9F; glyph_dd[2]  = 8'h25; glyph_dd[3]  = 8'h0D;
      glyph_dd[4]  = 8'h99; glyph_dd[5]  = 8'h49; glyph_dd[6]  = 8'h41; glyph_dd[7]  = 8'h1F;
      glyph_dd[8]  = 8'h01; glyph_dd[9]  = 8'h09; glyph_dd[10] = 8'h63; glyph_dd[11] = 8'h87;
      glyph_dd[12] = 8'h83; glyph_dd[13] = 8'h31; glyph_dd[14] = 8'h61; glyph_dd[15] = 8'hFD;

      // Reset values
      reset = 1'b1;
      set_all(6'b100001);
      tick();
      tick();
      check("reset an", an, 8'hFF);
      check("reset dd", dec_ddp, 8'hFF);
      reset = 1'b0;

      // All digits show '0'
      for (int s = 0; s < 8; s++) exp_dd[s] = 8'h03;
      run_frame(8'hFF, exp_dd);

      // Mixed glyphs, loaded at the frame boundary
      d[0] = 6'b110001; d[1] = 6'b100011; d[2] = 6'b110111; d[3] = 6'b111011;
      d[4] = 6'b111101; d[5] = 6'b111111; d[6] = 6'b100001; d[7] = 6'b111001;
      exp_dd[0] = 8'h01; exp_dd[1] = 8'h9F; exp_dd[2] = 8'h87; exp_dd[3] = 8'h31;
      exp_dd[4] = 8'h61; exp_dd[5] = 8'hFD; exp_dd[6] = 8'h03; exp_dd[7] = 8'h83;
      run_frame(8'hFF, exp_dd);

      // Sweep all sixteen codes over two frames
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 8; s++) begin
            d[s]      = {1'b1, 4'(f * 8 + s), 1'b1};
            exp_dd[s] = glyph_dd[f * 8 + s];
         end
         run_frame(8'hFF, exp_dd);
      end

      // Disabled digit d6 keeps its anode dark
      set_all(6'b100001);
      d[5] = 6'b000001;
      for (int s = 0; s < 8; s++) exp_dd[s] = 8'h03;
      run_frame(8'hDF, exp_dd);

      // Decimal point on d3 showing '3'
      set_all(6'b100001);
      d[2] = 6'b100110;
      exp_dd[2] = 8'h0C;
      run_frame(8'hFF, exp_dd);

      // Frame latch: d1 and d8 change mid-frame, visible only next frame
      set_all(6'b100001);
      d[0] = 6'b100011;
      for (int s = 0; s < 8; s++) exp_dd[s] = 8'h03;
      exp_dd[0] = 8'h9F;
      run_frame(8'hFF, exp_dd);
      for (int s = 0; s < 3; s++) run_slot(s, 1'b1, exp_dd[s]);
      d[0] = 6'b101111;
      d[7] = 6'b101111;
      for (int s = 3; s < 8; s++) run_slot(s, 1'b1, exp_dd[s]);
      exp_dd[0] = 8'h1F;
      exp_dd[7] = 8'h1F;
      run_frame(8'hFF, exp_dd);

      // Reset in the middle of slot 4
      set_all(6'b100001);
      for (int s = 0; s < 8; s++) exp_dd[s] = 8'h03;
      run_frame(8'hFF, exp_dd);
      for (int s = 0; s < 4; s++) run_slot(s, 1'b1, 8'h03);
      tick();
      check("slot4 guard before reset", an, 8'hFF);
      tick();
      check("slot4 lit before reset", an, 8'hEF);
      reset = 1'b1;
      #1;
      check("async reset an", an, 8'hFF);
      check("async reset dd", dec_ddp, 8'hFF);
      tick();
      check("held reset an", an, 8'hFF);
      reset = 1'b0;
      d[0] = 6'b101111;
      exp_dd[0] = 8'h1F;
      run_frame(8'hFF, exp_dd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
